// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the simplified I2C-style initiator.
package i2c_pkg;

   localparam int unsigned I2C_ADDR_W = 4;
   localparam int unsigned I2C_DATA_W = 4;

   // Address the bench responder answers to.
   localparam logic [3:0] I2C_RESP_ADDR = 4'b1100;

   typedef enum logic [3:0] {
      IDLE,
      START,
      ADDR,
      GAP,
      ACKW,
      RWB,
      READ,
      WRITE,
      COOL
   } i2c_state_e;

   function automatic int unsigned i2c_max(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/i2c_master_if.sv
// i2c_master_if: host command / responder link bundle for i2c_master.
// master = initiator view, slave = host + responder view.
interface i2c_master_if
   import i2c_pkg::*;
#(
   parameter int unsigned ADDR_W = I2C_ADDR_W,
   parameter int unsigned DATA_W = I2C_DATA_W
);

   logic              start;
   logic              rw;
   logic [ADDR_W-1:0] addr;
   logic              wdata;
   logic              ack;
   logic              sda;
   logic              busy;
   logic              done;
   logic              nack;
   logic [DATA_W-1:0] rdata;

   modport master (
      input  start, rw, addr, wdata, ack,
      output sda, busy, done, nack, rdata
   );

   modport slave (
      output start, rw, addr, wdata, ack,
      input  sda, busy, done, nack, rdata
   );

endinterface

// File: rtl/i2c_master_shreg.sv
// i2c_master_shreg: address shift-out / read-data shift-in register with a
// saturating bit down-counter; o_last flags the final bit of the current field.
module i2c_master_shreg
   import i2c_pkg::*;
#(
   parameter int unsigned W         = i2c_max(I2C_ADDR_W, I2C_DATA_W),
   parameter int unsigned LOAD_CNT  = I2C_ADDR_W - 1,
   parameter int unsigned REARM_CNT = I2C_DATA_W - 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_data,
   input  logic         i_rearm,
   input  logic         i_shift,
   input  logic         i_bit,
   output logic [W-1:0] o_data,
   output logic         o_last
);

   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

   logic [W-1:0]  r_data;
   logic [CW-1:0] r_cnt;

   // Load / shift data and count bits down, stopping at zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_data <= '0;
         r_cnt  <= '0;
      end else if (i_load) begin
         r_data <= i_load_data;
         r_cnt  <= CW'(LOAD_CNT);
      end else begin
         if (i_rearm) begin
            r_cnt <= CW'(REARM_CNT);
         end else if (i_shift && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
         end
         if (i_shift) begin
            r_data <= {r_data[W-2:0], i_bit};
         end
      end
   end

   assign o_data = r_data;
   assign o_last = (r_cnt == '0);

endmodule

// File: rtl/i2c_master.sv
// i2c_master: serialises one command (start, 4-bit address, ack slot, R/W,
// data) onto sda and returns read data or a nack flag.
// Optional feature: define I2C_MASTER_QUEUE_EN for a one-entry command buffer.
module i2c_master
   import i2c_pkg::*;
#(
   parameter int unsigned ADDR_W   = I2C_ADDR_W,
   parameter int unsigned DATA_W   = I2C_DATA_W,
   parameter int unsigned COOL_CYC = 2
) (
   input  logic         clk,
   input  logic         reset,
   i2c_master_if.master bus
);

   localparam int unsigned SH_W = i2c_max(ADDR_W, DATA_W);
   localparam int unsigned CC_W = $clog2(COOL_CYC);

   i2c_state_e        r_state, w_next_state;
   logic              r_rw, r_wdata, r_ack_q, r_nack;
   logic [DATA_W-1:0] r_rdata;
   logic [CC_W-1:0]   r_cool_cnt;

   logic              w_load, w_use_pend, w_rearm, w_shift;
   logic [ADDR_W-1:0] w_load_addr;
   logic              w_load_rw, w_load_wdata;
   logic [SH_W-1:0]   w_sh_data;
   logic              w_sh_last, w_cool_last, w_sda;
   logic [DATA_W-1:0] w_rdata_next;

   logic              w_pend_vld, w_pend_rw, w_pend_wdata;
   logic [ADDR_W-1:0] w_pend_addr;

   i2c_master_shreg #(
      .W        (SH_W),
      .LOAD_CNT (ADDR_W - 1),
      .REARM_CNT(DATA_W - 1)
   ) u_shreg (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_load),
      .i_load_data(SH_W'(w_load_addr) << (SH_W - ADDR_W)),
      .i_rearm    (w_rearm),
      .i_shift    (w_shift),
      .i_bit      (bus.ack),
      .o_data     (w_sh_data),
      .o_last     (w_sh_last)
   );

`ifdef I2C_MASTER_QUEUE_EN
   logic              r_pend_vld, r_pend_rw, r_pend_wdata;
   logic [ADDR_W-1:0] r_pend_addr;

   // Hold one command that arrives mid-frame until the FSM launches it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pend_vld   <= 1'b0;
         r_pend_rw    <= 1'b0;
         r_pend_wdata <= 1'b0;
         r_pend_addr  <= '0;
      end else if (w_use_pend) begin
         r_pend_vld <= 1'b0;
      end else if (bus.start && (r_state != IDLE) && !r_pend_vld) begin
         r_pend_vld   <= 1'b1;
         r_pend_rw    <= bus.rw;
         r_pend_wdata <= bus.wdata;
         r_pend_addr  <= bus.addr;
      end
   end

   assign w_pend_vld   = r_pend_vld;
   assign w_pend_rw    = r_pend_rw;
   assign w_pend_wdata = r_pend_wdata;
   assign w_pend_addr  = r_pend_addr;
`else
   assign w_pend_vld   = 1'b0;
   assign w_pend_rw    = 1'b0;
   assign w_pend_wdata = 1'b0;
   assign w_pend_addr  = '0;
`endif

   assign w_cool_last  = (r_cool_cnt == CC_W'(COOL_CYC - 1));
   assign w_rdata_next = {w_sh_data[DATA_W-2:0], bus.ack};

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state, shift-register control and sda per slot.
   always_comb begin
      w_next_state = r_state;
      w_load       = 1'b0;
      w_use_pend   = 1'b0;
      w_rearm      = 1'b0;
      w_shift      = 1'b0;
      w_load_addr  = bus.addr;
      w_load_rw    = bus.rw;
      w_load_wdata = bus.wdata;
      w_sda        = 1'b1;
      case (r_state)
         IDLE: begin
            if (w_pend_vld) begin
               w_next_state = START;
               w_load       = 1'b1;
               w_use_pend   = 1'b1;
            end else if (bus.start) begin
               w_next_state = START;
               w_load       = 1'b1;
            end
         end
         START: begin
            w_sda        = 1'b0;
            w_next_state = ADDR;
         end
         ADDR: begin
            w_sda   = w_sh_data[SH_W-1];
            w_shift = 1'b1;
            if (w_sh_last) w_next_state = GAP;
         end
         GAP:  w_next_state = ACKW;
         ACKW: w_next_state = RWB;
         RWB: begin
            w_sda = r_rw;
            if (!r_ack_q) begin
               w_next_state = COOL;
            end else if (r_rw) begin
               w_next_state = READ;
               w_rearm      = 1'b1;
            end else begin
               w_next_state = WRITE;
            end
         end
         READ: begin
            w_shift = 1'b1;
            if (w_sh_last) w_next_state = COOL;
         end
         WRITE: begin
            w_sda        = r_wdata;
            w_next_state = COOL;
         end
         COOL: begin
            if (w_cool_last) begin
               if (w_pend_vld) begin
                  w_next_state = START;
                  w_load       = 1'b1;
                  w_use_pend   = 1'b1;
               end else begin
                  w_next_state = IDLE;
               end
            end
         end
         default: w_next_state = IDLE;
      endcase
      if (w_use_pend) begin
         w_load_addr  = w_pend_addr;
         w_load_rw    = w_pend_rw;
         w_load_wdata = w_pend_wdata;
      end
   end

   // Command capture, ack sampling, nack/rdata results and cool-down count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rw       <= 1'b0;
         r_wdata    <= 1'b0;
         r_ack_q    <= 1'b0;
         r_nack     <= 1'b0;
         r_rdata    <= '0;
         r_cool_cnt <= '0;
      end else begin
         if (w_load) begin
            r_rw    <= w_load_rw;
            r_wdata <= w_load_wdata;
            r_nack  <= 1'b0;
         end
         if (r_state == ACKW) r_ack_q <= bus.ack;
         if ((r_state == RWB) && !r_ack_q) r_nack <= 1'b1;
         if ((r_state == READ) && w_sh_last) r_rdata <= w_rdata_next;
         r_cool_cnt <= ((r_state == COOL) && !w_cool_last) ? r_cool_cnt + CC_W'(1) : '0;
      end
   end

   assign bus.sda   = w_sda;
   assign bus.busy  = (r_state != IDLE);
   assign bus.done  = (r_state == COOL) && (r_cool_cnt == '0);
   assign bus.nack  = r_nack;
   assign bus.rdata = r_rdata;

endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: scoreboard bench for i2c_master with a reactive responder model.
module tb_i2c_master;
   import i2c_pkg::*;

   localparam int unsigned COOL_CYC = 2;

   typedef struct {
      logic [3:0] rdata;
      logic       nack;
      int         lat;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   i2c_master_if #(.ADDR_W(I2C_ADDR_W), .DATA_W(I2C_DATA_W)) bus ();

   i2c_master #(
      .ADDR_W  (I2C_ADDR_W),
      .DATA_W  (I2C_DATA_W),
      .COOL_CYC(COOL_CYC)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   exp_t sb[$];
   logic [3:0] model_rdata = 4'b0000;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Responder: samples sda on negedge, answers address 1100, returns rsp_msg MSB first.
   int         rsp_slot = -1;
   logic [3:0] rsp_addr = 4'b0000;
   logic [3:0] rsp_msg  = 4'b0000;
   logic       rsp_match = 1'b0, rsp_rw = 1'b0, rsp_out = 1'b0, rsp_ack = 1'b0;
   assign bus.ack = rsp_ack;

   always @(negedge clk or negedge reset) begin
      if (!reset) begin
         rsp_slot = -1;
         rsp_ack  = 1'b0;
      end else if (rsp_slot < 0) begin
         if (bus.sda == 1'b0) rsp_slot = 0;
      end else begin
         rsp_slot++;
         if (rsp_slot <= 4) begin
            rsp_addr = {rsp_addr[2:0], bus.sda};
         end else if (rsp_slot == 5) begin
            rsp_match = (rsp_addr == I2C_RESP_ADDR);
         end else if (rsp_slot == 6) begin
            rsp_ack = rsp_match;
         end else if (rsp_slot == 7) begin
            rsp_ack = 1'b0;
            rsp_rw  = bus.sda;
            if (!rsp_match) rsp_slot = -1;
         end else if (rsp_slot <= 11) begin
            if (rsp_rw) begin
               rsp_ack = rsp_msg[11 - rsp_slot];
            end else begin
               rsp_out  = bus.sda;
               rsp_slot = -1;
            end
         end else begin
            rsp_ack  = 1'b0;
            rsp_slot = -1;
         end
      end
   end

   // Monitor: frame starts, per-slot sda capture, done handling against the scoreboard.
   int   n_starts = 0, n_done = 0, s_cyc = 0, last_done_cyc = 0, last_gap = 0;
   bit   in_frame = 1'b0;
   logic frame_sda [16];
   exp_t e;

   always @(negedge clk) begin
      if (!reset) begin
         in_frame = 1'b0;
      end else begin
         if (!in_frame && bus.busy && (bus.sda == 1'b0)) begin
            in_frame = 1'b1;
            s_cyc    = cyc;
            last_gap = cyc - last_done_cyc;
            n_starts++;
         end
         if (in_frame && (cyc - s_cyc) < 16) frame_sda[cyc - s_cyc] = bus.sda;
         if (bus.done) begin
            n_done++;
            last_done_cyc = cyc;
            in_frame = 1'b0;
            check("done_expected", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("rdata", bus.rdata, e.rdata);
               check("nack", bus.nack, e.nack);
               check("done_latency", cyc - s_cyc, e.lat);
            end
         end
      end
   end

   int acc_cyc = 0;

   task automatic send(input logic [3:0] a, input logic r, input logic w);
      bus.addr  = a;
      bus.rw    = r;
      bus.wdata = w;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      acc_cyc   = cyc;
   endtask

   task automatic push_exp(input logic [3:0] a, input logic r);
      exp_t x;
      logic acked;
      acked = (a == I2C_RESP_ADDR);
      if (acked && r) model_rdata = rsp_msg;
      x.rdata = model_rdata;
      x.nack  = !acked;
      x.lat   = !acked ? 8 : (r ? 12 : 9);
      sb.push_back(x);
   endtask

   task automatic wait_dones(input int target, input string tag);
      int k = 0;
      while ((n_done < target) && (k < 200)) begin
         @(posedge clk);
         #1;
         k++;
      end
      check(tag, (n_done >= target), 1);
      repeat (4) @(posedge clk);
      #1;
   endtask

   int base_d, base_s, k6;

   initial begin
      reset      = 1'b0;
      bus.start  = 1'b0;
      bus.rw     = 1'b0;
      bus.addr   = '0;
      bus.wdata  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_sda", bus.sda, 1);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_nack", bus.nack, 0);
      check("rst_rdata", bus.rdata, 0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Read from the responder address.
      rsp_msg = 4'b1010;
      push_exp(4'b1100, 1'b1);
      send(4'b1100, 1'b1, 1'b0);
      check("t1_busy_in_S", bus.busy, 1);
      check("t1_sda_in_S", bus.sda, 0);
      wait_dones(1, "t1_done_seen");
      check("t1_start_slot", s_cyc, acc_cyc);
      check("t1_sda_S_to_S4", {frame_sda[0], frame_sda[1], frame_sda[2], frame_sda[3], frame_sda[4]}, 5'b01100);
      check("t1_sda_rwb", frame_sda[7], 1);

      // Writes with both data values.
      push_exp(4'b1100, 1'b0);
      send(4'b1100, 1'b0, 1'b1);
      wait_dones(2, "t2a_done_seen");
      check("t2a_sda_write", frame_sda[8], 1);
      check("t2a_resp_out", rsp_out, 1);
      push_exp(4'b1100, 1'b0);
      send(4'b1100, 1'b0, 1'b0);
      wait_dones(3, "t2b_done_seen");
      check("t2b_sda_write", frame_sda[8], 0);
      check("t2b_resp_out", rsp_out, 0);

      // Unacknowledged address.
      push_exp(4'b0011, 1'b1);
      send(4'b0011, 1'b1, 1'b0);
      wait_dones(4, "t3_done_seen");
      check("t3_nack_held", bus.nack, 1);
      check("t3_rdata_kept", bus.rdata, 4'b1010);

      // Reset during an address slot.
      base_d = n_done;
      send(4'b1100, 1'b1, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("t4_sda", bus.sda, 1);
      check("t4_busy", bus.busy, 0);
      check("t4_nack", bus.nack, 0);
      check("t4_rdata", bus.rdata, 0);
      model_rdata = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("t4_no_done", n_done, base_d);

      // Second read pattern; also clears nothing stale.
      rsp_msg = 4'b0110;
      push_exp(4'b1100, 1'b1);
      send(4'b1100, 1'b1, 1'b0);
      wait_dones(base_d + 1, "t1b_done_seen");

      // Start pulsed mid-frame.
      base_d = n_done;
      base_s = n_starts;
      rsp_msg = 4'b0101;
      push_exp(4'b1100, 1'b0);
      send(4'b1100, 1'b0, 1'b1);
      repeat (3) @(posedge clk);
      #1;
`ifdef I2C_MASTER_QUEUE_EN
      push_exp(4'b1100, 1'b1);
`endif
      send(4'b1100, 1'b1, 1'b0);
`ifdef I2C_MASTER_QUEUE_EN
      wait_dones(base_d + 2, "t5_done_seen");
      check("t5_queue_gap", last_gap, COOL_CYC);
      repeat (30) @(posedge clk);
      #1;
      check("t5_frames", n_starts - base_s, 2);
`else
      wait_dones(base_d + 1, "t5_done_seen");
      repeat (30) @(posedge clk);
      #1;
      check("t5_frames", n_starts - base_s, 1);
`endif

      // Back-to-back reads with start held high.
      base_d = n_done;
      base_s = n_starts;
      rsp_msg = 4'b1001;
      push_exp(4'b1100, 1'b1);
      push_exp(4'b1100, 1'b1);
      bus.addr  = 4'b1100;
      bus.rw    = 1'b1;
      bus.wdata = 1'b0;
      bus.start = 1'b1;
      k6 = 0;
      while ((n_starts < base_s + 2) && (k6 < 200)) begin
         @(negedge clk);
         #1;
         k6++;
      end
      bus.start = 1'b0;
      check("t6_two_starts", (n_starts >= base_s + 2), 1);
      wait_dones(base_d + 2, "t6_done_seen");
`ifdef I2C_MASTER_QUEUE_EN
      check("t6_gap", last_gap, COOL_CYC);
`else
      check("t6_gap", last_gap, COOL_CYC + 1);
`endif
      check("t6_gap_sda", {frame_sda[0], frame_sda[1]}, 2'b01);
      repeat (30) @(posedge clk);
      #1;
      check("t6_frames", n_starts - base_s, 2);
      check("sb_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
